// File: rtl/pulse_record_reader_pkg.sv
// Shared pulse record layout and frame constants.
// Used by the pulse processor and the record reader.
package pulse_record_reader_pkg;

  localparam int REC_W = 64;

  localparam int MAX_MSB = 63;
  localparam int MAX_LSB = 56;
  localparam int CNT_MSB = 55;
  localparam int CNT_LSB = 32;
  localparam int INT_MSB = 31;
  localparam int INT_LSB = 0;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  localparam logic [3:0] LAST_IDX = 4'd8;

  typedef enum logic {
    IDLE,
    SEND
  } ser_state_e;

  function automatic logic [7:0] rec_byte(
    input logic [REC_W-1:0] rec,
    input logic [2:0]       sel
  );
    return rec[{sel, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/pulse_record_reader_fifo.sv
// First-word-fall-through record FIFO.
// Pointers and level reset; storage does not.
module record_fifo
  import pulse_record_reader_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [REC_W-1:0]         wdata,
  output logic [REC_W-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/pulse_record_reader.sv
// Buffers pulse records and streams them as
// SYNC-prefixed 9-byte frames, LSB first.
module pulse_record_reader
  import pulse_record_reader_pkg::*;
#(
  parameter int         DEPTH = 8,
  parameter logic [7:0] SYNC  = SYNC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [REC_W-1:0]       count,
  input  logic                   ready,
  output logic                   halt,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ack,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            dropped
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] HALT_LVL = LW'(DEPTH - 1);

  ser_state_e       state, state_nx;
  logic [3:0]       idx, idx_nx;
  logic [REC_W-1:0] head;
  logic             hs, pop, free, push, drop;

  assign hs   = tx_valid & tx_ack;
  assign pop  = hs & (idx == LAST_IDX);
  assign free = (level < FULL_LVL) | pop;
  assign push = ready & free;
  assign drop = ready & ~free;

  // A push into a full FIFO only lands when the head
  // is popped on the same edge, so the head is never
  // overwritten mid-frame.
  record_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (count),
    .rdata (head),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt    <= 1'b0;
      dropped <= '0;
    end else begin
      halt <= (level >= HALT_LVL);
      if (drop && dropped != 16'hFFFF)
        dropped <= dropped + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      IDLE: begin
        if (level != '0) begin
          state_nx = SEND;
          idx_nx   = '0;
        end
      end
      SEND: begin
        if (tx_ack) begin
          if (idx == LAST_IDX) begin
            state_nx = IDLE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + 4'd1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  always_comb begin
    tx_valid = (state == SEND);
    tx_data  = 8'h00;
    unique case (1'b1)
      (state == SEND) && (idx == '0):
        tx_data = SYNC;
      (state == SEND) && (idx != '0):
        tx_data = rec_byte(head, 3'(idx - 4'd1));
      default:
        tx_data = 8'h00;
    endcase
  end

endmodule
